// File: rtl/ibex_ifetch.sv
// Instruction fetch stage: issues word fetches to the instruction SRAM, buffers
// returned words with their PCs, and hands them to ID over valid/ready.
module ibex_ifetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        sram_req,
  input  logic        sram_gnt,
  input  logic        sram_rvalid,
  output logic [9:0]  sram_addr,
  input  logic [31:0] sram_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_rdata,
  output logic [31:0] instr_pc,
  output logic        busy
);

  localparam int unsigned PW   = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned MAXD = 8;

  typedef enum logic {IDLE, REQ} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] tgt_pc_q, tgt_pc_d;
  logic        pend_q, pend_d;
  logic        drop_q, drop_d;
  logic        tgt_vld_q, tgt_vld_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] fifo_pc_q  [MAXD];
  logic [31:0] fifo_ins_q [MAXD];

  logic        grant, resp, push, pop;
  logic [31:0] tgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == int'(FIFO_DEPTH) - 1) return '0;
    return p + 1'b1;
  endfunction

  assign sram_req    = (state_q == REQ);
  assign sram_addr   = req_pc_q[11:2];
  assign instr_valid = (count_q != '0);
  assign instr_rdata = instr_valid ? fifo_ins_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]  : '0;
  assign busy        = sram_req || pend_q || instr_valid;

  always_comb begin
    grant     = (state_q == REQ) && sram_gnt;
    resp      = sram_rvalid && pend_q;
    push      = resp && !drop_q && !redirect;
    pop       = instr_valid && instr_ready && !redirect;
    tgt       = redirect_pc & ~32'h3;
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    pend_pc_d = pend_pc_q;
    tgt_pc_d  = tgt_pc_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    tgt_vld_d = tgt_vld_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (resp) begin
      pend_d = 1'b0;
      drop_d = 1'b0;
    end
    if (redirect && pend_q && !resp) drop_d = 1'b1;

    // An ungranted request must keep its address, so the target waits in tgt_pc.
    if (redirect) begin
      if ((state_q == REQ) && !grant) begin
        tgt_vld_d = 1'b1;
        tgt_pc_d  = tgt;
      end else begin
        req_pc_d = tgt;
      end
    end

    if (grant) begin
      pend_d    = 1'b1;
      pend_pc_d = req_pc_q;
      tgt_vld_d = 1'b0;
      if (redirect || tgt_vld_q) drop_d = 1'b1;
      if (!redirect) req_pc_d = tgt_vld_q ? tgt_pc_q : req_pc_q + 32'd4;
    end

    case (state_q)
      IDLE: begin
        if (fetch_en && !redirect &&
            (int'(count_q) + int'(pend_q) < int'(FIFO_DEPTH)))
          state_d = REQ;
      end
      REQ: begin
        // The just-granted word holds one slot; keep requesting only if another is free.
        if (grant)
          state_d = (fetch_en && !redirect && !tgt_vld_q &&
                     (int'(count_d) + 1 < int'(FIFO_DEPTH))) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_pc_q  <= BOOT_ADDR & ~32'h3;
      pend_q    <= 1'b0;
      drop_q    <= 1'b0;
      tgt_vld_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      tgt_vld_q <= tgt_vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
    tgt_pc_q  <= tgt_pc_d;
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= pend_pc_q;
      fifo_ins_q[wr_ptr_q] <= sram_rdata;
    end
  end

endmodule

// File: doc/ibex_ifetch.md
# ibex_ifetch

Instruction fetch stage sitting directly upstream of the instruction SRAM model, between it and the ID stage. Generates word-aligned fetch addresses, drives the SRAM request/grant/rvalid handshake, and buffers returned instructions with their PCs in a small FIFO. Presents one instruction at a time to ID over a valid/ready interface. Supports control-flow redirects, which flush buffered and in-flight instructions.

## Interface
- `BOOT_ADDR`, default 32'h0000_0080: PC fetched first after reset. Bits [1:0] are ignored.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Legal range is 2..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `fetch_en` in 1: when high, new SRAM requests may be issued.
- `redirect` in 1: one-cycle pulse that flushes the fetch stage and restarts fetch at `redirect_pc`.
- `redirect_pc` in 32: redirect target. Bits [1:0] are forced to 0.
- `sram_req` out 1: SRAM request.
- `sram_gnt` in 1: SRAM grant. The SRAM samples `sram_addr` in a cycle where `sram_req` and `sram_gnt` are both high.
- `sram_rvalid` in 1: read data valid. Arrives exactly 1 cycle after the grant cycle.
- `sram_addr` out 10: word address, equal to `req_pc[11:2]`.
- `sram_rdata` in 32: instruction word, valid when `sram_rvalid` is high.
- `instr_valid` out 1: FIFO head is valid.
- `instr_ready` in 1: ID accepts the head this cycle.
- `instr_rdata` out 32: head instruction.
- `instr_pc` out 32: PC of the head instruction.
- `busy` out 1: high if `sram_req` is high, a response is pending, or the FIFO is non-empty.

## Operation
- Registers:
  - `req_pc` (32 bits): address of the current or next request.
  - `pend`: a granted response is outstanding.
  - `pend_pc`: PC of the outstanding response.
  - `drop`: discard the outstanding response.
  - FIFO of {pc, instr} with `count`.
- Request FSM states:
  - IDLE: `sram_req`=0.
  - REQ: `sram_req`=1, with `sram_addr` held stable until the grant.
- IDLE→REQ when `fetch_en`=1, `redirect`=0, and `count + pend < FIFO_DEPTH`.
- In REQ, the grant cycle (`sram_gnt`=1) does the following:
  - Sets `pend`=1 and `pend_pc`=`req_pc`.
  - Sets `req_pc`=`req_pc+4`, using 32-bit wrap.
  - Stays in REQ if `fetch_en`=1 and `count+1 < FIFO_DEPTH`; otherwise goes to IDLE.
  - Back-to-back requests keep `sram_req` high, giving one grant every 2 cycles.
- In REQ without a grant, the FSM stays in REQ. The request is never withdrawn, even if `fetch_en` falls.
- Response cycle (`sram_rvalid`=1 with `pend`=1):
  - Clears `pend`.
  - If `drop`=0, pushes {`pend_pc`, `sram_rdata`}; otherwise discards the data and clears `drop`.
- `sram_rvalid` with `pend`=0 is ignored.
- Pop occurs when `instr_valid` and `instr_ready` are both high. Push and pop in the same cycle leave `count` unchanged.
- The credit rule guarantees that a push never finds the FIFO full.
- Redirect effects:
  - The FIFO is flushed: `count`←0, and `instr_valid`=0 from the next cycle.
  - `req_pc`←{`redirect_pc[31:2]`,2'b00}.
- Redirect and in-flight requests:
  - **REQ not yet granted:** the request stays asserted at its old address until granted, its response is dropped, and the FSM then re-enters REQ with the target.
  - **Redirect in the grant cycle:** that request's response is dropped, and the next request uses the target.
  - **`pend`=1, including a redirect in the same cycle as `sram_rvalid`:** that response is dropped.
  - **Redirect in the grant cycle when the FSM would otherwise stay in REQ:** the FSM goes to IDLE for 1 cycle.
- `fetch_en`=0 stops new requests only. Outstanding responses are still accepted and the FIFO still drains.
- Reset values:
  - `sram_req`=0, `sram_addr`=`BOOT_ADDR[11:2]`.
  - `instr_valid`=0, `instr_rdata`=0, `instr_pc`=0, `busy`=0.
  - `pend`=0, `drop`=0, `count`=0.
  - `req_pc`=`BOOT_ADDR` with bits [1:0] forced to 0.
  - FSM in IDLE.
- Reset mid-operation returns the block to these values immediately (asynchronously). Any later `sram_rvalid` is ignored because `pend`=0.

## Timing
- Cycle 0 is the first edge after `rst` falls, with `fetch_en`=1:
  - Cycle 0: `sram_req` rises.
  - Cycle 1: grant.
  - Cycle 2: rvalid.
  - Cycle 3: `instr_valid`=1. There is no bypass.
- Steady state with `instr_ready`=1 delivers 1 instruction per 2 cycles.
- Redirect issued in cycle N with the FSM in IDLE and `pend`=0:
  - N+1: `sram_req`=1 at the target.
  - N+4: first target instruction valid.
- FIFO outputs are driven from the head registers, not combinationally from SRAM data.

## Test plan
- **Reset/boot:** `BOOT_ADDR`=0x80, imem[0x20]=0x00000013, `fetch_en`=1 → cycle 0 `sram_addr`=0x020; cycle 3 `instr_valid`=1, `instr_pc`=0x80, `instr_rdata`=0x00000013.
- **Streaming:** `instr_ready`=1 → PCs 0x80, 0x84, 0x88 valid in cycles 3, 5, 7 with matching imem words.
- **Backpressure:** `instr_ready`=0 → FIFO holds 2 entries, `sram_req` drops, and no grants occur. Raising `instr_ready` → in-order delivery 0x80, 0x84, 0x88 with no loss or duplication.
- **Redirect:**
  - Redirect to 0x200 in the grant cycle of 0x88 → the 0x88 response is dropped, the FIFO is cleared, `sram_addr`=0x080 is issued next, and the next `instr_pc` is 0x200.
  - Repeat with the redirect in the same cycle as `sram_rvalid`.
- **Wrap:** redirect to 0xFFC → `sram_addr`=0x3FF, then 0x000. Output PCs are 0xFFC and 0x1000.
- **Reset mid-response:** assert `rst` the cycle after a grant → all outputs at reset values, the late rvalid is ignored, and `instr_valid` stays 0 until a new fetch from 0x80.
